// File: rtl/truth_sweep_if.sv
// Sweep handshake bundle between the truth-table sweeper and the logic under test.
// Optional pass/fail signals exist only when SWEEP_CHECK_EN is defined.
interface truth_sweep_if;
    logic        start;
    logic        w;
    logic        x;
    logic        y;
    logic        z;
    logic        F1;
    logic        F2;
    logic [3:0]  index;
    logic        busy;
    logic        done;
    logic [15:0] f1_table;
    logic [15:0] f2_table;
`ifdef SWEEP_CHECK_EN
    logic        pass;
    logic        fail;

    modport master (
        input  start, F1, F2,
        output w, x, y, z, index, busy, done,
        output f1_table, f2_table, pass, fail
    );
    modport slave (
        output start, F1, F2,
        input  w, x, y, z, index, busy, done,
        input  f1_table, f2_table, pass, fail
    );
`else
    modport master (
        input  start, F1, F2,
        output w, x, y, z, index, busy, done,
        output f1_table, f2_table
    );
    modport slave (
        output start, F1, F2,
        input  w, x, y, z, index, busy, done,
        input  f1_table, f2_table
    );
`endif
endinterface

// File: rtl/truth_sweep.sv
// Steps {w,x,y,z} through 0..15, holding each for HOLD cycles, and records F1/F2.
// SWEEP_CHECK_EN adds pass/fail comparison against EXP_F1/EXP_F2.
module truth_sweep #(
    parameter int unsigned HOLD = 10
`ifdef SWEEP_CHECK_EN
    ,
    parameter logic [15:0] EXP_F1 = 16'h0000,
    parameter logic [15:0] EXP_F2 = 16'h0000
`endif
) (
    input logic         clk,
    input logic         rst,
    truth_sweep_if.master bus
);

    typedef enum logic [1:0] {IDLE, HOLD_ST, CAPTURE, DONE} state_t;

    // CAPTURE is the final hold cycle, so HOLD_ST lasts HOLD-1 cycles
    localparam logic [7:0] LAST = 8'(HOLD - 2);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [3:0]  idx, idx_n;
    logic [15:0] f1, f1_n;
    logic [15:0] f2, f2_n;
`ifdef SWEEP_CHECK_EN
    logic        pass, pass_n;
    logic        fail, fail_n;
    logic        match;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            f1    <= '0;
            f2    <= '0;
`ifdef SWEEP_CHECK_EN
            pass  <= 1'b0;
            fail  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            f1    <= f1_n;
            f2    <= f2_n;
`ifdef SWEEP_CHECK_EN
            pass  <= pass_n;
            fail  <= fail_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        f1_n    = f1;
        f2_n    = f2;
`ifdef SWEEP_CHECK_EN
        pass_n  = pass;
        fail_n  = fail;
        match   = 1'b0;
`endif
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = HOLD_ST;
                    cnt_n   = '0;
                    idx_n   = '0;
                    f1_n    = '0;
                    f2_n    = '0;
`ifdef SWEEP_CHECK_EN
                    pass_n  = 1'b0;
                    fail_n  = 1'b0;
`endif
                end
            end
            HOLD_ST: begin
                cnt_n = cnt + 8'd1;
                if (cnt == LAST) state_n = CAPTURE;
            end
            CAPTURE: begin
                f1_n[idx] = bus.F1;
                f2_n[idx] = bus.F2;
                cnt_n     = '0;
                if (idx == 4'hF) begin
                    state_n = DONE;
`ifdef SWEEP_CHECK_EN
                    match  = (f1_n == EXP_F1) && (f2_n == EXP_F2);
                    pass_n = match;
                    fail_n = !match;
`endif
                end else begin
                    idx_n   = idx + 4'd1;
                    state_n = HOLD_ST;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign {bus.w, bus.x, bus.y, bus.z} = idx;
    assign bus.index    = idx;
    assign bus.busy     = (state == HOLD_ST) || (state == CAPTURE);
    assign bus.done     = (state == DONE);
    assign bus.f1_table = f1;
    assign bus.f2_table = f2;
`ifdef SWEEP_CHECK_EN
    assign bus.pass     = pass;
    assign bus.fail     = fail;
`else
`endif

endmodule

// File: tb/tb_truth_sweep.sv
// Table-driven bench for truth_sweep: two instances (HOLD=10 and HOLD=2)
// swept against several reference functions plus reset/start corner cases.
module tb_truth_sweep;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    int   mode;
    int   cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    truth_sweep_if ia();
    truth_sweep_if ib();

    function automatic logic [1:0] resp(input int m, input logic [3:0] v);
        case (m)
            0:       return {v[3] & v[2], v[0]};
            1:       return {~v[1], v[3] ^ v[2]};
            2:       return {v[1], ~v[0]};
            default: return {|v, &v};
        endcase
    endfunction

    assign ia.start = start_a;
    assign ib.start = start_b;
    assign {ia.F1, ia.F2} = resp(mode, {ia.w, ia.x, ia.y, ia.z});
    assign {ib.F1, ib.F2} = resp(mode, {ib.w, ib.x, ib.y, ib.z});

    truth_sweep #(
        .HOLD(10)
`ifdef SWEEP_CHECK_EN
        , .EXP_F1(16'hF000), .EXP_F2(16'hAAAA)
`endif
    ) u_a (.clk(clk), .rst(rst), .bus(ia));

    truth_sweep #(
        .HOLD(2)
`ifdef SWEEP_CHECK_EN
        , .EXP_F1(16'h3333), .EXP_F2(16'h0FF0)
`endif
    ) u_b (.clk(clk), .rst(rst), .bus(ib));

    logic [3:0]  idx_s, wxyz_s;
    logic        busy_s, done_s;
    logic [15:0] t1_s, t2_s;
`ifdef SWEEP_CHECK_EN
    logic        pass_s, fail_s;
`endif

    always_comb begin
        if (cur == 0) begin
            idx_s  = ia.index;
            wxyz_s = {ia.w, ia.x, ia.y, ia.z};
            busy_s = ia.busy;
            done_s = ia.done;
            t1_s   = ia.f1_table;
            t2_s   = ia.f2_table;
        end else begin
            idx_s  = ib.index;
            wxyz_s = {ib.w, ib.x, ib.y, ib.z};
            busy_s = ib.busy;
            done_s = ib.done;
            t1_s   = ib.f1_table;
            t2_s   = ib.f2_table;
        end
    end
`ifdef SWEEP_CHECK_EN
    assign pass_s = (cur == 0) ? ia.pass : ib.pass;
    assign fail_s = (cur == 0) ? ia.fail : ib.fail;
`endif

    typedef struct {
        int          m;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_idx"},  32'(idx_s), 0);
        check({nm, "_wxyz"}, 32'(wxyz_s), 0);
        check({nm, "_busy"}, 32'(busy_s), 0);
        check({nm, "_done"}, 32'(done_s), 0);
        check({nm, "_t1"},   32'(t1_s), 0);
        check({nm, "_t2"},   32'(t2_s), 0);
    endtask

    task automatic run_sweep(input int sel, input int hold,
                             input logic [15:0] e1, input logic [15:0] e2,
                             input int poke);
        int         cycles;
        int         run;
        int         bad;
        logic [3:0] prev;
        cur = sel;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        check("start_busy", 32'(busy_s), 1);
        check("start_done", 32'(done_s), 0);
        check("start_t1", 32'(t1_s), 0);
        check("start_t2", 32'(t2_s), 0);
        check("start_idx", 32'(idx_s), 0);
`ifdef SWEEP_CHECK_EN
        check("start_pf", {30'd0, pass_s, fail_s}, 0);
`endif
        cycles = 0;
        run    = 0;
        bad    = 0;
        prev   = 4'd0;
        while (busy_s && cycles < 20 * hold + 20) begin
            if (wxyz_s != idx_s) bad++;
            if (idx_s == prev) begin
                run++;
            end else begin
                if (run != hold || idx_s != prev + 4'd1) bad++;
                prev = idx_s;
                run  = 1;
            end
            cycles++;
            set_start(sel, (poke != 0) && (cycles == poke));
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        if (run != hold || prev != 4'hF) bad++;
        check("busy_cycles", 32'(cycles), 32'(16 * hold));
        check("hold_seq", 32'(bad), 0);
        check("end_done", 32'(done_s), 1);
        check("end_idx", 32'(idx_s), 15);
        check("end_t1", 32'(t1_s), 32'(e1));
        check("end_t2", 32'(t2_s), 32'(e2));
`ifdef SWEEP_CHECK_EN
        if (sel == 0) begin
            if (e1 == 16'hF000 && e2 == 16'hAAAA)
                check("pass_fail", {30'd0, pass_s, fail_s}, 2);
            else
                check("pass_fail", {30'd0, pass_s, fail_s}, 1);
        end else begin
            if (e1 == 16'h3333 && e2 == 16'h0FF0)
                check("pass_fail", {30'd0, pass_s, fail_s}, 2);
            else
                check("pass_fail", {30'd0, pass_s, fail_s}, 1);
        end
`endif
        repeat (3) @(negedge clk);
        check("hold_t1", 32'(t1_s), 32'(e1));
        check("hold_done", 32'(done_s), 1);
    endtask

    initial begin
        int guard;
        vecs[0] = '{0, 16'hF000, 16'hAAAA};
        vecs[1] = '{1, 16'h3333, 16'h0FF0};
        vecs[2] = '{2, 16'hCCCC, 16'h5555};
        vecs[3] = '{3, 16'hFFFE, 16'h8000};

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode    = 0;
        cur     = 0;
        repeat (2) @(negedge clk);
        check_zero("rst_a");
        cur = 1;
        check_zero("rst_b");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle_b");

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                mode = vecs[i].m;
                run_sweep(s, (s == 0) ? 10 : 2, vecs[i].e1, vecs[i].e2, 0);
            end
        end

        // A second start mid-sweep must not restart or stretch it
        mode = 0;
        run_sweep(0, 10, 16'hF000, 16'hAAAA, 50);

        // Abort mid-hold with reset
        cur = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        guard = 0;
        while (idx_s != 4'd7 && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        check("reach_idx7", 32'(idx_s), 7);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_rst");
        run_sweep(0, 10, 16'hF000, 16'hAAAA, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
